// File: rtl/ioctl_upload_reader_pkg.sv
// Shared ioctl definitions: upload FSM states, address width, file indices.
package ioctl_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, LATCH} upload_state_t;

    localparam int         IOCTL_ADDR_W = 25;
    localparam logic [7:0] BIOS_INDEX   = 8'd0;
    localparam logic [7:0] SAVE_INDEX   = 8'd2;

endpackage

// File: rtl/ioctl_upload_reader_if.sv
// hps_io upload read channel plus the core RAM read port.
interface ioctl_upload_reader_if
    import ioctl_pkg::*;
#(
    parameter int ADDR_W = 14
);
    logic                    ioctl_upload;
    logic [7:0]              ioctl_index;
    logic                    ioctl_rd;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_din;
    logic                    ioctl_wait;
    logic [ADDR_W-1:0]       mem_addr;
    logic                    mem_rd;
    logic [7:0]              mem_dout;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout,
        input  ioctl_din, ioctl_wait, mem_addr, mem_rd
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout,
        output ioctl_din, ioctl_wait, mem_addr, mem_rd
    );
endinterface

// File: rtl/ioctl_upload_reader_checksum.sv
// 16-bit wrapping byte accumulator with synchronous clear and enable.
module upload_checksum (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_sum
);
    logic [15:0] r_sum;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= i_en ? {8'h00, i_data} : 16'h0000;
        end else if (i_en) begin
            r_sum <= r_sum + {8'h00, i_data};
        end
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/ioctl_upload_reader.sv
// Serves hps_io upload reads from fixed-latency core RAM.
// Optional checksum output: define IOCTL_UPLOAD_CHECKSUM_EN.
module ioctl_upload_reader
    import ioctl_pkg::*;
#(
    parameter logic [7:0] UPLOAD_INDEX = SAVE_INDEX,
    parameter int         ADDR_W       = 14,
    parameter int         MEM_LATENCY  = 2,
    parameter logic [7:0] FILL_BYTE    = 8'hFF
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    ioctl_upload_reader_if.slave    bus,
    output logic                    upload_active,
    output logic                    upload_done,
    output logic [IOCTL_ADDR_W-1:0] bytes_sent
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    ,
    output logic [15:0]             checksum
`endif
);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    upload_state_t           r_state, w_next;
    logic [3:0]              r_cnt, w_cnt_next;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [7:0]              r_din;
    logic                    r_active, r_done;
    logic [IOCTL_ADDR_W-1:0] r_bytes;

    logic       w_sel, w_in_win, w_accept, w_latch;
    logic       w_din_upd, w_rise;
    logic [7:0] w_din_val;

    assign w_sel     = bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
    assign w_in_win  = bus.ioctl_addr[IOCTL_ADDR_W-1:ADDR_W] == '0;
    assign w_accept  = w_sel && bus.ioctl_rd && (r_state == IDLE);
    assign w_rise    = w_sel && !r_active;
    assign w_din_upd = w_latch || (w_accept && !w_in_win);
    assign w_din_val = w_latch ? bus.mem_dout : FILL_BYTE;

    // Losing sel abandons any fetch in flight without touching ioctl_din.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_latch    = 1'b0;
        if (!w_sel) begin
            w_next     = IDLE;
            w_cnt_next = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept && w_in_win) begin
                        w_next     = FETCH;
                        w_cnt_next = LAT_M1;
                    end
                end
                FETCH, WAIT: begin
                    if (r_cnt == '0) begin
                        w_next = LATCH;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                LATCH: begin
                    w_next  = IDLE;
                    w_latch = 1'b1;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_din      <= 8'h00;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_bytes    <= '0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_active <= w_sel;
            r_done   <= r_active && !w_sel;
            if (w_accept) r_mem_addr <= bus.ioctl_addr[ADDR_W-1:0];
            if (w_din_upd) r_din <= w_din_val;
            if (w_rise) begin
                r_bytes <= w_din_upd ? IOCTL_ADDR_W'(1) : '0;
            end else if (w_din_upd && r_bytes != '1) begin
                r_bytes <= r_bytes + IOCTL_ADDR_W'(1);
            end
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_rd     = (r_state == FETCH);
    assign bus.ioctl_din  = r_din;
    assign bus.ioctl_wait = w_sel && (w_accept || r_state != IDLE);
    assign upload_active  = r_active;
    assign upload_done    = r_done;
    assign bytes_sent     = r_bytes;

`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    upload_checksum u_csum (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_clr   (w_rise),
        .i_en    (w_din_upd),
        .i_data  (w_din_val),
        .o_sum   (checksum)
    );
`endif

    cover property (@(posedge clk_sys) disable iff (!reset_n)
        w_sel && bus.ioctl_rd && r_state != IDLE);
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Self-checking bench for ioctl_upload_reader: vector table, corner sequences, random vs model.
module tb_ioctl_upload_reader;
    localparam int         LAT  = 2;
    localparam int         AW   = 14;
    localparam logic [7:0] FILL = 8'hFF;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        upload_active, upload_done;
    logic [24:0] bytes_sent;
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] ram  [0:(1<<AW)-1];
    logic [7:0] pipe [1:LAT];

    ioctl_upload_reader_if #(.ADDR_W(AW)) bus ();

    ioctl_upload_reader #(
        .UPLOAD_INDEX (8'd2),
        .ADDR_W       (AW),
        .MEM_LATENCY  (LAT),
        .FILL_BYTE    (FILL)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .upload_active (upload_active),
        .upload_done   (upload_done),
        .bytes_sent    (bytes_sent)
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // RAM with LAT cycles of read latency; junk on the bus when not reading.
    always @(posedge clk_sys) begin
        pipe[1] <= bus.mem_rd ? ram[bus.mem_addr] : 8'($urandom);
        for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_dout = pipe[LAT];

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        int          nw;
        int          nrd;
        logic [7:0]  din;
        int          bytes;
        logic        act;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    // One rd pulse, then observe 12 cycles.
    task automatic do_read(input logic [24:0] a, input logic [7:0] ix,
                           output int nw, output int nrd, output int rdcyc,
                           output logic [AW-1:0] ra, output logic [7:0] dfall);
        bit got;
        nw = 0; nrd = 0; rdcyc = -1; ra = '0; dfall = '0; got = 0;
        bus.ioctl_index = ix;
        bus.ioctl_addr  = a;
        bus.ioctl_rd    = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (bus.ioctl_wait) nw++;
            else if (!got) begin
                got   = 1;
                dfall = bus.ioctl_din;
            end
            if (bus.mem_rd) begin
                nrd++;
                rdcyc = c;
                ra    = bus.mem_addr;
            end
            step();
            bus.ioctl_rd = 1'b0;
            #1;
        end
    endtask

    int               nw, nrd, rdc, dones;
    logic [AW-1:0]    ra;
    logic [7:0]       df;
    int               m_bytes;
    logic [15:0]      m_sum;
    logic [7:0]       m_din;
    bit               m_prev, sel, inwin, upl;
    logic [7:0]       rix;
    logic [24:0]      ra25;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);
        ram[14'h0010] = 8'hA5; ram[14'h3FFF] = 8'h5C; ram[14'h0000] = 8'h3C;
        ram[14'h0030] = 8'h77; ram[14'h0031] = 8'h88; ram[14'h0040] = 8'h99;
        ram[14'h0021] = 8'h02; ram[14'h0022] = 8'h10;

        vecs[0] = '{8'd2, 25'h0000010, 2 + LAT, 1, 8'hA5, 1, 1'b1};
        vecs[1] = '{8'd2, 25'h0004000, 1,       0, FILL,  2, 1'b1};
        vecs[2] = '{8'd0, 25'h0000010, 0,       0, FILL,  2, 1'b0};
        vecs[3] = '{8'd2, 25'h0003FFF, 2 + LAT, 1, 8'h5C, 1, 1'b1};
        vecs[4] = '{8'd2, 25'h1FFFFFF, 1,       0, FILL,  2, 1'b1};
        vecs[5] = '{8'd2, 25'h0000000, 2 + LAT, 1, 8'h3C, 3, 1'b1};

        reset_n = 1'b0;
        bus.ioctl_upload = 1'b0; bus.ioctl_index = 8'd0;
        bus.ioctl_rd = 1'b0; bus.ioctl_addr = '0;
        repeat (3) step();
        chk("rst_din",   32'(bus.ioctl_din), 32'h0);
        chk("rst_wait",  32'(bus.ioctl_wait), 32'h0);
        chk("rst_memrd", 32'(bus.mem_rd), 32'h0);
        chk("rst_maddr", 32'(bus.mem_addr), 32'h0);
        chk("rst_act",   32'(upload_active), 32'h0);
        chk("rst_done",  32'(upload_done), 32'h0);
        chk("rst_bytes", 32'(bytes_sent), 32'h0);
        reset_n = 1'b1;

        bus.ioctl_upload = 1'b1; bus.ioctl_index = 8'd2;
        step(); step();
        chk("sess_act", 32'(upload_active), 32'h1);

        foreach (vecs[i]) begin
            do_read(vecs[i].addr, vecs[i].idx, nw, nrd, rdc, ra, df);
            chk($sformatf("v%0d_wait", i), 32'(nw), 32'(vecs[i].nw));
            chk($sformatf("v%0d_memrd", i), 32'(nrd), 32'(vecs[i].nrd));
            if (vecs[i].nrd > 0) begin
                chk($sformatf("v%0d_rdcyc", i), 32'(rdc), 32'd1);
                chk($sformatf("v%0d_maddr", i), 32'(ra), 32'(vecs[i].addr[AW-1:0]));
            end
            chk($sformatf("v%0d_din", i), 32'(df), 32'(vecs[i].din));
            chk($sformatf("v%0d_bytes", i), 32'(bytes_sent), 32'(vecs[i].bytes));
            chk($sformatf("v%0d_act", i), 32'(upload_active), 32'(vecs[i].act));
        end

        // Second rd while busy is dropped.
        bus.ioctl_index = 8'd2; bus.ioctl_addr = 25'h30; bus.ioctl_rd = 1'b1;
        #1;
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_rd) nrd++;
            if (c == 2 + LAT) begin
                chk("busy_din", 32'(bus.ioctl_din), 32'h77);
                chk("busy_wait", 32'(bus.ioctl_wait), 32'h0);
            end
            step();
            bus.ioctl_rd = (c + 1 == 2);
            if (c + 1 == 2) bus.ioctl_addr = 25'h31;
            #1;
        end
        chk("busy_memrd", 32'(nrd), 32'd1);
        chk("busy_bytes", 32'(bytes_sent), 32'd4);
        chk("busy_dinend", 32'(bus.ioctl_din), 32'h77);

        // Drop the session at cycle 2 of a fetch.
        bus.ioctl_addr = 25'h40; bus.ioctl_rd = 1'b1;
        #1;
        nrd = 0; dones = 0; nw = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_rd) nrd++;
            if (c >= 2 && bus.ioctl_wait) nw++;
            if (upload_done) dones++;
            step();
            bus.ioctl_rd = 1'b0;
            if (c + 1 == 2) bus.ioctl_upload = 1'b0;
            #1;
        end
        chk("abort_memrd", 32'(nrd), 32'd1);
        chk("abort_wait", 32'(nw), 32'd0);
        chk("abort_done", 32'(dones), 32'd1);
        chk("abort_din", 32'(bus.ioctl_din), 32'h77);
        chk("abort_bytes", 32'(bytes_sent), 32'd4);
        chk("abort_act", 32'(upload_active), 32'h0);

        // Asynchronous reset while mem_rd is high.
        bus.ioctl_upload = 1'b1;
        step(); step();
        do_read(25'h4000, 8'd2, nw, nrd, rdc, ra, df);
        chk("pre_rst_bytes", 32'(bytes_sent), 32'd1);
        bus.ioctl_addr = 25'h10; bus.ioctl_rd = 1'b1;
        step();
        bus.ioctl_rd = 1'b0;
        #1;
        chk("pre_rst_memrd", 32'(bus.mem_rd), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("arst_din",   32'(bus.ioctl_din), 32'h0);
        chk("arst_wait",  32'(bus.ioctl_wait), 32'h0);
        chk("arst_memrd", 32'(bus.mem_rd), 32'h0);
        chk("arst_maddr", 32'(bus.mem_addr), 32'h0);
        chk("arst_act",   32'(upload_active), 32'h0);
        chk("arst_bytes", 32'(bytes_sent), 32'h0);
        step(); step();
        reset_n = 1'b1;
        step(); step();

`ifdef IOCTL_UPLOAD_CHECKSUM_EN
        do_read(25'h4000, 8'd2, nw, nrd, rdc, ra, df);
        do_read(25'h0021, 8'd2, nw, nrd, rdc, ra, df);
        do_read(25'h0022, 8'd2, nw, nrd, rdc, ra, df);
        chk("csum_sum", 32'(checksum), 32'h0111);
        chk("csum_bytes", 32'(bytes_sent), 32'd3);
`endif

        // Random traffic against the reference model.
        bus.ioctl_upload = 1'b0;
        step(); step();
        bus.ioctl_upload = 1'b1;
        step(); step();
        do_read(25'h4000, 8'd2, nw, nrd, rdc, ra, df);
        m_bytes = 1; m_sum = 16'(FILL); m_din = FILL; m_prev = 1;
        for (int n = 0; n < 40; n++) begin
            upl  = ($urandom % 8) != 0;
            rix  = ($urandom % 6 == 0) ? 8'($urandom) : 8'd2;
            ra25 = ($urandom % 4 == 0) ? 25'($urandom) : 25'($urandom % (1 << AW));
            sel   = upl && rix == 8'd2;
            inwin = ra25 < (1 << AW);
            if (sel && !m_prev) begin
                m_bytes = 0;
                m_sum   = 0;
            end
            bus.ioctl_upload = upl;
            do_read(ra25, rix, nw, nrd, rdc, ra, df);
            if (sel) begin
                m_din = inwin ? ram[ra25[AW-1:0]] : FILL;
                m_bytes++;
                m_sum = m_sum + 16'(m_din);
            end
            m_prev = sel;
            chk($sformatf("r%0d_wait", n), 32'(nw),
                32'(sel ? (inwin ? 2 + LAT : 1) : 0));
            chk($sformatf("r%0d_memrd", n), 32'(nrd), 32'(sel && inwin));
            chk($sformatf("r%0d_din", n), 32'(df), 32'(m_din));
            chk($sformatf("r%0d_bytes", n), 32'(bytes_sent), 32'(m_bytes));
            chk($sformatf("r%0d_act", n), 32'(upload_active), 32'(sel));
`ifdef IOCTL_UPLOAD_CHECKSUM_EN
            chk($sformatf("r%0d_csum", n), 32'(checksum), 32'(m_sum));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
